// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 stage: scheduler states, default frame
// geometry and a width helper used by the scheduler, window buffer and MAC.
package conv1_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2,
    S_FIN    = 2'd3
  } conv1_state_e;

  localparam int unsigned CONV1_WIDTH    = 28;
  localparam int unsigned CONV1_HEIGHT   = 28;
  localparam int unsigned CONV1_NUM_FILT = 6;

  // clog2 that never returns 0, so a single-entry range still gets a 1-bit field
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv1_addr_gen.sv
// Image read-address counter for one filter pass. Issues NPIX reads, then
// parks on the last address. The window-buffer valid follows the read enable
// one cycle late (memory latency) and then stays high until the pass ends.
module conv1_addr_gen #(
  parameter int unsigned NPIX = 784,
  parameter int unsigned AW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,    // scheduler is in STREAM
  input  logic          clr_i,    // scheduler leaves STREAM next cycle
  input  logic          rearm_i,  // GAP: valid comes back with the next pass
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          vld_o
);

  // One extra bit so the counter can represent "all NPIX reads issued"
  localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

  logic [AW:0] rd_q, rd_d;
  logic        vld_q, vld_d;
  logic        in_range;

  // Read enable and clamped address from the counter
  always_comb begin
    in_range  = (rd_q < NPIX_W);
    rd_en_o   = run_i & in_range;
    rd_addr_o = in_range ? rd_q[AW-1:0] : AW'(NPIX - 1);
    vld_o     = vld_q;
  end

  // Next-state for the counter and the delayed valid
  always_comb begin
    rd_d  = rd_q;
    vld_d = vld_q | rd_en_o | rearm_i;
    if (clr_i) begin
      rd_d  = '0;
      vld_d = 1'b0;
    end else if (rd_en_o) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Counter and valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/conv1_sched.sv
// Frame scheduler for the first convolution layer. For each filter it streams
// the whole image through the 3x3 window buffer and writes one feature-map
// entry per valid window. Filters are separated by a one-cycle GAP that drops
// the buffer valid to flush the window buffer.
module conv1_sched
  import conv1_pkg::*;
#(
  parameter  int unsigned WIDTH     = CONV1_WIDTH,
  parameter  int unsigned HEIGHT    = CONV1_HEIGHT,
  parameter  int unsigned NUM_FILT  = CONV1_NUM_FILT,
  parameter  int unsigned DATA_BITS = 32,
  localparam int unsigned NPIX      = WIDTH * HEIGHT,
  localparam int unsigned NWIN      = (WIDTH - 2) * (HEIGHT - 2),
  localparam int unsigned AW        = $clog2(NPIX),
  localparam int unsigned OW        = $clog2(NUM_FILT * NWIN),
  localparam int unsigned FW        = clog2_min1(NUM_FILT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          win_valid,
  output logic          img_rd_en,
  output logic [AW-1:0] img_rd_addr,
  output logic          buf_valid_in,
  output logic [FW-1:0] filt_sel,
  output logic          out_wr_en,
  output logic [OW-1:0] out_wr_addr,
  output logic          busy,
  output logic          done
);

  // A 3x3 window needs at least a 3x3 image; pixel width only matters downstream
  if (WIDTH < 3 || HEIGHT < 3 || NUM_FILT < 1 || DATA_BITS < 1) begin : g_bad_param
    $error("conv1_sched: unsupported parameter set");
  end

  localparam int unsigned WW = clog2_min1(NWIN);

  conv1_state_e  state_q, state_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [WW-1:0] win_q, win_d;
  logic [OW-1:0] wr_q, wr_d;

  logic          wr_fire;
  logic          last_win;
  logic          last_filt;
  logic          ag_rd_en;
  logic [AW-1:0] ag_rd_addr;
  logic          ag_vld;

  // Window accept: only in STREAM, and never in the cycle abort is seen
  always_comb begin
    wr_fire   = (state_q == S_STREAM) & win_valid & ~abort;
    last_win  = (win_q == WW'(NWIN - 1));
    last_filt = (filt_q == FW'(NUM_FILT - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start) state_d = S_STREAM;
        S_STREAM: if (win_valid && last_win) state_d = last_filt ? S_FIN : S_GAP;
        S_GAP:    state_d = S_STREAM;
        S_FIN:    state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Filter / window / write-address counters. The write address runs
  // continuously across filters, so it always equals filt*NWIN + win.
  always_comb begin
    filt_d = filt_q;
    win_d  = win_q;
    wr_d   = wr_q;
    if (state_d == S_IDLE) begin
      filt_d = '0;
      win_d  = '0;
      wr_d   = '0;
    end else if (state_q == S_GAP) begin
      filt_d = filt_q + 1'b1;
      win_d  = '0;
    end else if (wr_fire) begin
      win_d = win_q + 1'b1;
      wr_d  = wr_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      win_q  <= '0;
      wr_q   <= '0;
    end else begin
      filt_q <= filt_d;
      win_q  <= win_d;
      wr_q   <= wr_d;
    end
  end

  conv1_addr_gen #(
    .NPIX (NPIX),
    .AW   (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q == S_STREAM),
    .clr_i     (state_d != S_STREAM),
    .rearm_i   (state_q == S_GAP),
    .rd_en_o   (ag_rd_en),
    .rd_addr_o (ag_rd_addr),
    .vld_o     (ag_vld)
  );

  // Output decode from state and counters
  always_comb begin
    img_rd_en    = ag_rd_en;
    img_rd_addr  = ag_rd_addr;
    buf_valid_in = ag_vld;
    filt_sel     = filt_q;
    out_wr_en    = wr_fire;
    out_wr_addr  = wr_fire ? wr_q : '0;
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_FIN) & ~abort;
  end

endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched on a 5x5 image with two filters (9 windows each).
// A window model turns buf_valid_in into win_valid; a frame-level model
// predicts every output each cycle; directed steps pin boundary behaviour.
module tb_conv1_sched;

  localparam int NPIX = 25;
  localparam int NWIN = 9;
  localparam int NF   = 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, win_valid;
  logic       img_rd_en, buf_valid_in, out_wr_en, busy, done;
  logic [4:0] img_rd_addr, out_wr_addr;
  logic [0:0] filt_sel;

  always #5 clk = ~clk;

  conv1_sched #(.WIDTH(5), .HEIGHT(5), .NUM_FILT(2), .DATA_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_valid(win_valid),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .buf_valid_in(buf_valid_in),
    .filt_sel(filt_sel), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .busy(busy), .done(done)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // Window model: each buffer-valid cycle delivers the next raster pixel;
  // a 3x3 window completes on pixels with row>=2 and col>=2.
  bit   wm_en = 1'b1, stray = 1'b0, gap_stray = 1'b0;
  int   pix = 0;
  logic prev_bv = 1'b0;
  initial begin
    win_valid = 1'b0;
    forever begin
      bit w;
      @(posedge clk);
      #1;
      w = 1'b0;
      if (buf_valid_in === 1'b1) begin
        if (pix < NPIX && pix / 5 >= 2 && pix % 5 >= 2) w = 1'b1;
        pix++;
      end else begin
        pix = 0;
      end
      if (gap_stray && prev_bv === 1'b1 && buf_valid_in === 1'b0 && busy === 1'b1) w = 1'b1;
      prev_bv   = buf_valid_in;
      win_valid = wm_en ? w : stray;
    end
  end

  // Frame model: phase 0 idle, 1 streaming, 2 gap, 3 finish
  int ph = 0, mf = 0, mrd = 0, mwin = 0;
  bit mbv = 1'b0;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1 || abort === 1'b1) begin
        ph = 0; mf = 0; mrd = 0; mwin = 0; mbv = 1'b0;
      end else begin
        case (ph)
          0: if (start === 1'b1) begin
               ph = 1; mf = 0; mrd = 0; mwin = 0; mbv = 1'b0;
             end
          1: begin
               mbv = mbv || (mrd < NPIX);
               if (mrd < NPIX) mrd++;
               if (win_valid === 1'b1) begin
                 if (mwin == NWIN - 1) begin
                   ph = (mf < NF - 1) ? 2 : 3; mrd = 0; mwin = 0; mbv = 1'b0;
                 end else begin
                   mwin++;
                 end
               end
             end
          2: begin ph = 1; mf++; mrd = 0; mwin = 0; mbv = 1'b1; end
          default: begin ph = 0; mf = 0; mbv = 1'b0; end
        endcase
      end
    end
  end

  // Per-cycle compare against the model, plus write/done logging
  int wq[$];
  int n_done = 0;
  initial begin
    forever begin
      bit ewr;
      @(negedge clk);
      ewr = (ph == 1) && (win_valid === 1'b1) && (abort !== 1'b1);
      chk("busy",         busy,         ph != 0);
      chk("done",         done,         (ph == 3) && (abort !== 1'b1));
      chk("img_rd_en",    img_rd_en,    (ph == 1) && (mrd < NPIX));
      chk("img_rd_addr",  img_rd_addr,  (ph == 1) ? ((mrd < NPIX) ? mrd : NPIX - 1) : 0);
      chk("buf_valid_in", buf_valid_in, mbv);
      chk("filt_sel",     filt_sel,     mf);
      chk("out_wr_en",    out_wr_en,    ewr);
      chk("out_wr_addr",  out_wr_addr,  ewr ? mf * NWIN + mwin : 0);
      if (out_wr_en === 1'b1) wq.push_back(int'(out_wr_addr));
      if (done === 1'b1) n_done++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (busy !== 1'b0 && k < 400);
    if (k >= 400) fail_timeout(nm);
  endtask

  task automatic check_frame(input string nm, input int nw, input int nd);
    chk({nm, " write count"}, wq.size(), nw);
    foreach (wq[i]) chk({nm, " write addr"}, wq[i], i);
    chk({nm, " done count"}, n_done, nd);
  endtask

  task automatic clear_log();
    wq.delete();
    n_done = 0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", busy, 0);
    chk("reset buf_valid_in", buf_valid_in, 0);
    chk("reset img_rd_en", img_rd_en, 0);
    chk("reset out_wr_en", out_wr_en, 0);
    rst_n = 1'b1;

    // Nominal frame with read-bound and filter-boundary pins
    clear_log();
    pulse_start();
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(img_rd_en === 1'b1 && img_rd_addr == 5'd24) && k < 100);
    if (k >= 100) fail_timeout("last read");
    @(negedge clk);
    chk("bound img_rd_en", img_rd_en, 0);
    chk("bound img_rd_addr", img_rd_addr, 24);
    chk("bound buf_valid_in", buf_valid_in, 1);
    chk("bound out_wr_en", out_wr_en, 1);
    chk("bound out_wr_addr", out_wr_addr, 8);
    @(negedge clk);
    chk("gap buf_valid_in", buf_valid_in, 0);
    chk("gap img_rd_en", img_rd_en, 0);
    chk("gap busy", busy, 1);
    @(negedge clk);
    chk("restart buf_valid_in", buf_valid_in, 1);
    chk("restart img_rd_en", img_rd_en, 1);
    chk("restart img_rd_addr", img_rd_addr, 0);
    chk("restart filt_sel", filt_sel, 1);
    wait_idle("nominal idle");
    check_frame("nominal", 18, 1);

    // Abort after the 5th write, then a clean frame
    clear_log();
    pulse_start();
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(out_wr_en === 1'b1 && out_wr_addr == 5'd4) && k < 100);
    if (k >= 100) fail_timeout("5th write");
    @(posedge clk); #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort buf_valid_in", buf_valid_in, 0);
    repeat (20) @(negedge clk);
    check_frame("aborted", 5, 0);
    clear_log();
    pulse_start();
    wait_idle("post-abort idle");
    check_frame("post-abort", 18, 1);

    // Reset in the middle of STREAM
    clear_log();
    pulse_start();
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-reset busy", busy, 0);
    chk("mid-reset buf_valid_in", buf_valid_in, 0);
    chk("mid-reset img_rd_en", img_rd_en, 0);
    chk("mid-reset img_rd_addr", img_rd_addr, 0);
    chk("mid-reset filt_sel", filt_sel, 0);
    chk("mid-reset out_wr_en", out_wr_en, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    repeat (12) @(negedge clk);
    check_frame("after reset", 0, 0);

    // Starts while busy are ignored
    clear_log();
    pulse_start();
    repeat (8) @(posedge clk);
    pulse_start();
    repeat (25) @(posedge clk);
    pulse_start();
    wait_idle("busy-start idle");
    check_frame("busy-start", 18, 1);
    repeat (3) @(negedge clk);
    chk("stays idle", busy, 0);

    // Stray win_valid in IDLE, then in GAP (and FIN)
    clear_log();
    @(posedge clk); #2 wm_en = 1'b0; stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle stray out_wr_en", out_wr_en, 0);
    @(posedge clk); #2 stray = 1'b0; wm_en = 1'b1;
    gap_stray = 1'b1;
    pulse_start();
    wait_idle("stray idle");
    check_frame("stray", 18, 1);
    gap_stray = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv1_sched.md
CONV1_SCHED -- requirements
Module: conv1_sched

Interface
REQ-001 Parameters SHALL be: WIDTH, default 28, image columns; HEIGHT, default 28, image rows; NUM_FILT, default 6, number of filters; DATA_BITS, default 32, pixel width.
REQ-002 Derived constants SHALL be: NPIX = WIDTH*HEIGHT; NWIN = (WIDTH-2)*(HEIGHT-2); AW = clog2(NPIX); OW = clog2(NUM_FILT*NWIN); FW = max(1, clog2(NUM_FILT)).
REQ-003 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to process one frame; sampled only in IDLE.
REQ-006 abort  in  1  synchronous abort; highest priority after reset.
REQ-007 win_valid  in  1  window-valid strobe from the 3x3 window buffer.
REQ-008 img_rd_en  out  1  image memory read enable; the memory returns data 1 cycle later.
REQ-009 img_rd_addr  out  AW  image memory read address.
REQ-010 buf_valid_in  out  1  valid_in to the window buffer; low for one cycle clears the buffer.
REQ-011 filt_sel  out  FW  filter index for the weight ROM and MAC.
REQ-012 out_wr_en  out  1  feature-map write enable.
REQ-013 out_wr_addr  out  OW  feature-map write address.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  single-cycle pulse when a frame completes.

Function
REQ-016 The FSM SHALL have the states IDLE, STREAM, GAP and FIN.
REQ-017 IDLE->STREAM SHALL occur on start; filt_sel, rd_addr, win_cnt and wr_addr SHALL be cleared to 0.
REQ-018 In STREAM, img_rd_en SHALL be 1 while rd_addr < NPIX; rd_addr SHALL increment each enabled cycle, then hold at NPIX-1 with img_rd_en=0.
REQ-019 buf_valid_in SHALL be img_rd_en delayed by one register while reads are issued, and SHALL remain 1 after the last read until the filter pass ends.
REQ-020 In STREAM, each win_valid=1 cycle SHALL produce out_wr_en=1 in the same cycle at out_wr_addr = filt_sel*NWIN + win_cnt; win_cnt then SHALL increment.
REQ-021 win_valid outside STREAM SHALL be ignored: no write and no count.
REQ-022 When win_valid=1 and win_cnt == NWIN-1, the FSM SHALL exit STREAM: to GAP if filt_sel < NUM_FILT-1, else to FIN.
REQ-023 GAP SHALL last exactly 1 cycle with buf_valid_in=0, then return to STREAM with filt_sel+1, rd_addr=0 and win_cnt=0.
REQ-024 FIN SHALL last 1 cycle with done=1 and buf_valid_in=0, then go to IDLE.
REQ-025 abort in any state SHALL force IDLE next cycle with all outputs 0 and no done pulse.
REQ-026 start while busy SHALL be ignored; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-027 out_wr_en and img_rd_en SHALL never be 1 in IDLE, GAP or FIN.

Reset
REQ-028 On rst_n low, the FSM SHALL go to IDLE and all counters and all outputs SHALL be 0, including mid-frame; no done SHALL follow the release of reset.

Structure
REQ-029 A shared conv1_pkg SHALL hold the state enum and the default WIDTH, HEIGHT and NUM_FILT constants, for reuse by conv1_buf and the MAC.
REQ-030 A single sub-module, conv1_addr_gen (rd_addr counter with delayed valid), SHALL exist; the FSM and write counters SHALL stay in the top level.

Verification (WIDTH=HEIGHT=5, NUM_FILT=2, NWIN=9)
REQ-031 Nominal: one start with a window model -> 18 writes at addresses 0..17, filt_sel 0 then 1, exactly one done, then busy=0.
REQ-032 Filter boundary: 9th win_valid of filter 0 -> buf_valid_in=0 for exactly 1 cycle, then reads restart at address 0 with filt_sel=1.
REQ-033 Read bound: after 25 reads -> img_rd_en=0 and img_rd_addr held at 24, with buf_valid_in still 1.
REQ-034 Abort after the 5th write -> IDLE next cycle, no further writes, no done; a following start runs a clean 18-write frame.
REQ-035 Reset asserted mid-STREAM -> all outputs 0 asynchronously; start pulses during busy -> ignored, frame still yields 18 writes.
REQ-036 Stray win_valid in IDLE and GAP -> no out_wr_en and win_cnt unchanged.
